// File: rtl/alu_seq_unit.sv
// alu_seq_unit: sequential ALU between the AC/DR/E/INPR register file and the
// control sequencer. Operands are captured on the accept edge. All results are
// registered and presented with a one-cycle alu_done strobe.
// Optional feature macro: ALU_MUL_EN enables the shift-add multiply on code 0101.
// Without it, 0101 is reported as illegal and no multiplier logic is built.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for alu_start
// S_RUN  | multi-cycle op (N-rotate / multiply), one step per clock
// S_DONE | result strobe cycle; a new alu_start is accepted here too
module alu_seq_unit #(
  parameter int WIDTH      = 16,
  parameter int INPR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_start,
  input  logic [3:0]            alu_code,
  input  logic [WIDTH-1:0]      ac_outdata,
  input  logic [WIDTH-1:0]      dr_outdata,
  input  logic                  e_outdata,
  input  logic [INPR_WIDTH-1:0] inpr_outdata,
  output logic [WIDTH-1:0]      alu_outdata,
  output logic                  e_indata,
  output logic                  ac_we,
  output logic                  ff_en,
  output logic                  alu_busy,
  output logic                  alu_done,
  output logic                  alu_illegal
);

  localparam int SHCNT_W = $clog2(WIDTH);
  // one extra bit so the counter can hold WIDTH for the multiply
  localparam int CNT_W   = SHCNT_W + 1;

  localparam logic [3:0] C_AND = 4'b0001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_LDA = 4'b0011;
  localparam logic [3:0] C_ROR = 4'b0100;
  localparam logic [3:0] C_MUL = 4'b0101;
  localparam logic [3:0] C_SUB = 4'b0110;
  localparam logic [3:0] C_ROL = 4'b0111;
  localparam logic [3:0] C_CMA = 4'b1001;
  localparam logic [3:0] C_CME = 4'b1010;
  localparam logic [3:0] C_CIR = 4'b1011;
  localparam logic [3:0] C_CIL = 4'b1100;
  localparam logic [3:0] C_INP = 4'b1101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_ac;
  logic               r_e;
  logic [3:0]         r_code;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_alu_outdata;
  logic               r_e_indata;
  logic               r_ac_we;
  logic               r_ff_en;
  logic               r_busy;
  logic               r_done;
  logic               r_illegal;
`ifdef ALU_MUL_EN
  logic [WIDTH-1:0]   r_dr;
  logic [WIDTH-1:0]   r_mhi;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH-1:0]   w_mhi_next;
`endif

  logic [WIDTH:0]     w_add;
  logic [WIDTH-1:0]   w_res_ac;
  logic               w_res_e;
  logic               w_ac_we;
  logic               w_ff_en;
  logic               w_illegal;
  logic               w_multi;
  logic [CNT_W-1:0]   w_cnt_init;
  logic [WIDTH-1:0]   w_step_ac;
  logic               w_step_e;
  logic [CNT_W-1:0]   w_cnt_dec;
  logic               w_accept;

  assign w_add     = {1'b0, ac_outdata} + {1'b0, dr_outdata};
  assign w_cnt_dec = r_cnt - CNT_W'(1);
  assign w_accept  = alu_start && (r_state == S_IDLE || r_state == S_DONE);

  // Decode the incoming code: single-cycle result, enables, and whether a RUN phase is needed
  always_comb begin
    w_res_ac   = ac_outdata;
    w_res_e    = e_outdata;
    w_ac_we    = 1'b0;
    w_ff_en    = 1'b0;
    w_illegal  = 1'b0;
    w_multi    = 1'b0;
    w_cnt_init = '0;
    case (alu_code)
      C_AND: begin
        w_res_ac = ac_outdata & dr_outdata;
        w_ac_we  = 1'b1;
      end
      C_ADD: begin
        w_res_ac = w_add[WIDTH-1:0];
        w_res_e  = w_add[WIDTH];
        w_ac_we  = 1'b1;
        w_ff_en  = 1'b1;
      end
      C_LDA: begin
        w_res_ac = dr_outdata;
        w_ac_we  = 1'b1;
      end
      C_SUB: begin
        w_res_ac = ac_outdata - dr_outdata;
        w_res_e  = (ac_outdata >= dr_outdata);
        w_ac_we  = 1'b1;
        w_ff_en  = 1'b1;
      end
      C_CMA: begin
        w_res_ac = ~ac_outdata;
        w_ac_we  = 1'b1;
      end
      C_CME: begin
        w_res_e = ~e_outdata;
        w_ff_en = 1'b1;
      end
      C_CIR: begin
        w_res_ac = {e_outdata, ac_outdata[WIDTH-1:1]};
        w_res_e  = ac_outdata[0];
        w_ac_we  = 1'b1;
        w_ff_en  = 1'b1;
      end
      C_CIL: begin
        w_res_ac = {ac_outdata[WIDTH-2:0], e_outdata};
        w_res_e  = ac_outdata[WIDTH-1];
        w_ac_we  = 1'b1;
        w_ff_en  = 1'b1;
      end
      C_INP: begin
        w_res_ac[INPR_WIDTH-1:0] = inpr_outdata;
        w_ac_we = 1'b1;
      end
      // a zero count finishes immediately with the captured {E,AC}
      C_ROR, C_ROL: begin
        w_cnt_init = {1'b0, dr_outdata[SHCNT_W-1:0]};
        w_multi    = |dr_outdata[SHCNT_W-1:0];
        w_ac_we    = 1'b1;
        w_ff_en    = 1'b1;
      end
`ifdef ALU_MUL_EN
      C_MUL: begin
        w_cnt_init = CNT_W'(WIDTH);
        w_multi    = 1'b1;
        w_ac_we    = 1'b1;
        w_ff_en    = 1'b1;
      end
`endif
      default: w_illegal = 1'b1;
    endcase
  end

  // One RUN step: rotate the {E,AC} ring by one, or one shift-add multiply iteration
  always_comb begin
    w_step_ac = r_ac;
    w_step_e  = r_e;
`ifdef ALU_MUL_EN
    // AC holds the multiplier and shifts out as the product low half fills in from the top
    w_mul_sum  = {1'b0, r_mhi} + (r_ac[0] ? {1'b0, r_dr} : '0);
    w_mhi_next = w_mul_sum[WIDTH:1];
`endif
    case (r_code)
      C_ROR: begin
        w_step_ac = {r_e, r_ac[WIDTH-1:1]};
        w_step_e  = r_ac[0];
      end
      C_ROL: begin
        w_step_ac = {r_ac[WIDTH-2:0], r_e};
        w_step_e  = r_ac[WIDTH-1];
      end
`ifdef ALU_MUL_EN
      C_MUL: begin
        w_step_ac = {w_mul_sum[0], r_ac[WIDTH-1:1]};
        w_step_e  = |w_mhi_next;
      end
`endif
      default: ;
    endcase
  end

  // Control FSM with registered result, strobes and down-counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_ac          <= '0;
      r_e           <= 1'b0;
      r_code        <= '0;
      r_cnt         <= '0;
      r_alu_outdata <= '0;
      r_e_indata    <= 1'b0;
      r_ac_we       <= 1'b0;
      r_ff_en       <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_illegal     <= 1'b0;
`ifdef ALU_MUL_EN
      r_dr          <= '0;
      r_mhi         <= '0;
`endif
    end else begin
      r_done    <= 1'b0;
      r_ac_we   <= 1'b0;
      r_ff_en   <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            if (w_multi) begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
              r_ac    <= ac_outdata;
              r_e     <= e_outdata;
              r_code  <= alu_code;
              r_cnt   <= w_cnt_init;
`ifdef ALU_MUL_EN
              r_dr    <= dr_outdata;
              r_mhi   <= '0;
`endif
            end else begin
              r_state       <= S_DONE;
              r_done        <= 1'b1;
              r_alu_outdata <= w_res_ac;
              r_e_indata    <= w_res_e;
              r_ac_we       <= w_ac_we;
              r_ff_en       <= w_ff_en;
              r_illegal     <= w_illegal;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_ac  <= w_step_ac;
          r_e   <= w_step_e;
          r_cnt <= w_cnt_dec;
`ifdef ALU_MUL_EN
          r_mhi <= w_mhi_next;
`endif
          if (w_cnt_dec == '0) begin
            r_state       <= S_DONE;
            r_busy        <= 1'b0;
            r_done        <= 1'b1;
            r_alu_outdata <= w_step_ac;
            r_e_indata    <= w_step_e;
            r_ac_we       <= 1'b1;
            r_ff_en       <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign alu_outdata = r_alu_outdata;
  assign e_indata    = r_e_indata;
  assign ac_we       = r_ac_we;
  assign ff_en       = r_ff_en;
  assign alu_busy    = r_busy;
  assign alu_done    = r_done;
  assign alu_illegal = r_illegal;

endmodule
